clock_edge_recovery: RTL and testbench

Consumer-side counterpart to our clock dividers: takes a slow, asynchronous, clock-like input (e.g. codec BCLK/LRCLK or a divided clock from another domain) into the clk_in domain. Produces single-cycle rise/fall strobes, measures the period in clk_in cycles, and reports lock/timeout status. Downstream audio logic uses the strobes as clock enables instead of clocking off the slow signal.

---
 rtl/clk_recovery_pkg.sv | 19 +
 rtl/sync_edge_detect.sv | 30 +++
 rtl/clock_edge_recovery.sv | 138 +++++++++++++
 tb/tb_clock_edge_recovery.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/clk_recovery_pkg.sv
// Shared types and helpers for the slow-clock edge recovery block.
package clk_recovery_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    // Counter width that can hold the value max_period itself.
    function automatic int period_width(input int max_period);
        return $clog2(max_period + 1);
    endfunction

    function automatic logic [31:0] abs_diff(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchroniser for a slow asynchronous clock, plus an edge flop
// that turns its transitions into single-cycle rise/fall strobes.
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_in,
    input  logic async_sig,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= async_sig;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign level = s2;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/clock_edge_recovery.sv
// Brings a slow asynchronous clock into the clk_in domain as edge strobes,
// measures its rise-to-rise period and reports lock / timeout status.
//
// state   | meaning
// IDLE    | no reference edge yet (after reset or timeout)
// MEASURE | reporting periods, counting consecutive matches toward lock
// LOCKED  | period stable against a frozen reference
module clock_edge_recovery
    import clk_recovery_pkg::*;
#(
    parameter  int MAX_PERIOD = 256,
    parameter  int LOCK_COUNT = 4,
    parameter  int TOLERANCE  = 1,
    localparam int PW         = period_width(MAX_PERIOD)
) (
    input  logic          clk_in,
    input  logic          rst_in,
    input  logic          slow_clk_in,
    output logic          level_out,
    output logic          rise_out,
    output logic          fall_out,
    output logic [PW-1:0] period_out,
    output logic          period_valid_out,
    output logic          locked_out,
    output logic          timeout_out
);

    localparam int MW = $clog2(LOCK_COUNT + 1);

    logic          rise_evt;
    logic [PW-1:0] cnt_q;
    logic [PW-1:0] ref_q, ref_d;
    logic [PW-1:0] period_q, period_d;
    logic [MW-1:0] match_q, match_d;
    logic          pvalid_q, pvalid_d;
    logic          locked_q, locked_d;
    logic          timeout_q, timeout_d;
    logic          in_tol;
    logic          at_max;
    state_t        state_q, state_d;

    sync_edge_detect u_sync (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .async_sig (slow_clk_in),
        .level     (level_out),
        .rise      (rise_evt),
        .fall      (fall_out)
    );

    assign rise_out = rise_evt;

    // Counts cycles since the last rise strobe; saturating keeps the timeout sticky-safe.
    always_ff @(posedge clk_in) begin
        if (rst_in)
            cnt_q <= '0;
        else if (rise_evt)
            cnt_q <= PW'(1);
        else if (cnt_q != PW'(MAX_PERIOD))
            cnt_q <= cnt_q + 1'b1;
    end

    assign in_tol = abs_diff(32'(cnt_q), 32'(ref_q)) <= 32'(TOLERANCE);
    assign at_max = (cnt_q == PW'(MAX_PERIOD));

    always_comb begin
        state_d   = state_q;
        ref_d     = ref_q;
        period_d  = period_q;
        match_d   = match_q;
        pvalid_d  = 1'b0;
        locked_d  = locked_q;
        timeout_d = timeout_q;

        if (rise_evt) begin
            timeout_d = 1'b0;
            unique case (state_q)
                IDLE: state_d = MEASURE;
                MEASURE: begin
                    period_d = cnt_q;
                    pvalid_d = 1'b1;
                    ref_d    = cnt_q;
                    // match_q == 0 means no earlier period since IDLE to compare against
                    if (match_q != '0 && in_tol)
                        match_d = match_q + 1'b1;
                    else
                        match_d = MW'(1);
                    if (match_d == MW'(LOCK_COUNT)) begin
                        state_d  = LOCKED;
                        locked_d = 1'b1;
                    end
                end
                LOCKED: begin
                    period_d = cnt_q;
                    pvalid_d = 1'b1;
                    if (!in_tol) begin
                        locked_d = 1'b0;
                        match_d  = MW'(1);
                        ref_d    = cnt_q;
                        state_d  = MEASURE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end else if (state_q != IDLE && at_max) begin
            timeout_d = 1'b1;
            locked_d  = 1'b0;
            match_d   = '0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q   <= IDLE;
            ref_q     <= '0;
            period_q  <= '0;
            match_q   <= '0;
            pvalid_q  <= 1'b0;
            locked_q  <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ref_q     <= ref_d;
            period_q  <= period_d;
            match_q   <= match_d;
            pvalid_q  <= pvalid_d;
            locked_q  <= locked_d;
            timeout_q <= timeout_d;
        end
    end

    assign period_out       = period_q;
    assign period_valid_out = pvalid_q;
    assign locked_out       = locked_q;
    assign timeout_out      = timeout_q;

endmodule

// File: tb/tb_clock_edge_recovery.sv
// Bench for clock_edge_recovery: a cycle-stamp reference model feeds an
// expected-output queue that is compared every cycle, plus directed checks.
module tb_clock_edge_recovery;

    localparam int MAX_P = 256;
    localparam int LOCK  = 4;
    localparam int TOL   = 1;
    localparam int PW    = 9;

    logic          clk_in = 1'b0;
    logic          rst_in = 1'b1;
    logic          slow_clk_in = 1'b0;
    logic          level_out, rise_out, fall_out;
    logic [PW-1:0] period_out;
    logic          period_valid_out, locked_out, timeout_out;
    logic [14:0]   outs;

    int n_vec  = 0;
    int n_miss = 0;

    clock_edge_recovery dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .slow_clk_in      (slow_clk_in),
        .level_out        (level_out),
        .rise_out         (rise_out),
        .fall_out         (fall_out),
        .period_out       (period_out),
        .period_valid_out (period_valid_out),
        .locked_out       (locked_out),
        .timeout_out      (timeout_out)
    );

    always #5 clk_in = ~clk_in;

    assign outs = {level_out, rise_out, fall_out, period_valid_out, locked_out, timeout_out, period_out};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int absd(input int a, input int b);
        return (a > b) ? a - b : b - a;
    endfunction

    // Reference model: periods from absolute cycle stamps of rise strobes.
    logic [14:0] exp_q[$];
    bit m_s1, m_s2, m_s3, m_pvalid, m_locked, m_timeout;
    int m_state, m_match, m_ref, m_period, m_last, m_cyc;

    task automatic model_step();
        bit rise_c;
        int p;
        rise_c   = m_s2 && !m_s3;
        m_pvalid = 1'b0;
        if (rst_in) begin
            {m_s1, m_s2, m_s3, m_locked, m_timeout} = '0;
            m_state = 0; m_match = 0; m_ref = 0; m_period = 0;
        end else begin
            if (rise_c) begin
                m_timeout = 1'b0;
                p = (m_cyc - m_last > MAX_P) ? MAX_P : m_cyc - m_last;
                case (m_state)
                    0: m_state = 1;
                    1: begin
                        m_period = p; m_pvalid = 1'b1;
                        if (m_match != 0 && absd(p, m_ref) <= TOL) m_match++;
                        else m_match = 1;
                        m_ref = p;
                        if (m_match == LOCK) begin m_state = 2; m_locked = 1'b1; end
                    end
                    default: begin
                        m_period = p; m_pvalid = 1'b1;
                        if (absd(p, m_ref) > TOL) begin
                            m_locked = 1'b0; m_match = 1; m_ref = p; m_state = 1;
                        end
                    end
                endcase
                m_last = m_cyc;
            end else if (m_state != 0 && m_cyc - m_last >= MAX_P) begin
                m_timeout = 1'b1; m_locked = 1'b0; m_match = 0; m_state = 0;
            end
            m_s3 = m_s2; m_s2 = m_s1; m_s1 = slow_clk_in;
        end
        m_cyc++;
        exp_q.push_back({m_s2, m_s2 & ~m_s3, ~m_s2 & m_s3, m_pvalid, m_locked, m_timeout, 9'(m_period)});
    endtask

    initial begin
        m_cyc = 0; m_last = 0;
        forever begin
            @(posedge clk_in);
            model_step();
        end
    end

    // Monitor: scoreboard pop plus event bookkeeping for directed checks.
    int ncyc = 0, last_rise = 0, last_fall = 0, n_pvalid = 0, tmo_delay = -1;
    bit tmo_prev = 1'b0;
    initial begin
        logic [14:0] e;
        forever begin
            @(negedge clk_in);
            ncyc++;
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("cycle_outs", 32'(outs), 32'(e));
            end
            if (rise_out) last_rise = ncyc;
            if (fall_out) last_fall = ncyc;
            if (period_valid_out) n_pvalid++;
            if (timeout_out && !tmo_prev) tmo_delay = ncyc - last_rise;
            tmo_prev = timeout_out;
        end
    end

    task automatic drive(input bit v);
        slow_clk_in = v;
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_period(input int hi, input int lo);
        repeat (hi) drive(1'b1);
        repeat (lo) drive(1'b0);
    endtask

    initial begin
        int pv0;
        rst_in = 1'b1;
        repeat (3) drive(1'b0);
        rst_in = 1'b0;
        check("reset_outs", 32'(outs), 32'h0);

        // divide-by-4: lock lands on the 5th rise
        repeat (4) run_period(2, 2);
        check("div4_unlocked_4th", 32'(locked_out), 32'd0);
        run_period(2, 2);
        check("div4_locked_5th", 32'(locked_out), 32'd1);
        check("div4_period", 32'(period_out), 32'd4);

        // alternating 4/5 holds lock; a single 8 drops it
        run_period(2, 2); run_period(3, 2); run_period(2, 2); run_period(3, 2);
        run_period(4, 4);
        check("alt_locked_held", 32'(locked_out), 32'd1);
        run_period(4, 4);
        check("p8_drop_lock", 32'(locked_out), 32'd0);
        check("p8_period", 32'(period_out), 32'd8);
        run_period(4, 4); run_period(4, 4);
        check("p8_relock_pending", 32'(locked_out), 32'd0);
        run_period(4, 4); run_period(4, 4);
        check("p8_relocked", 32'(locked_out), 32'd1);

        // hold low: timeout becomes visible one cycle after the counter hits MAX
        for (int i = 0; i < 400 && !timeout_out; i++) drive(1'b0);
        check("timeout_seen", 32'(timeout_out), 32'd1);
        check("timeout_unlock", 32'(locked_out), 32'd0);
        drive(1'b0);
        check("timeout_delay", 32'(tmo_delay), 32'(MAX_P + 1));

        // first rise after timeout clears it without a period; next rise is exactly 256 later
        pv0 = n_pvalid;
        run_period(2, 254);
        check("tmo_clear", 32'(timeout_out), 32'd0);
        check("tmo_no_pvalid", 32'(n_pvalid), 32'(pv0));
        run_period(2, 2);
        check("p256_period", 32'(period_out), 32'(MAX_P));
        check("p256_pvalid", 32'(n_pvalid), 32'(pv0 + 1));
        check("p256_no_timeout", 32'(timeout_out), 32'd0);

        // relock then reset mid-lock
        repeat (6) run_period(2, 2);
        check("relock_before_rst", 32'(locked_out), 32'd1);
        rst_in = 1'b1;
        drive(1'b0);
        rst_in = 1'b0;
        check("rst_midlock_outs", 32'(outs), 32'h0);
        pv0 = n_pvalid;
        run_period(2, 2);
        check("rst_first_rise_nop", 32'(n_pvalid), 32'(pv0));
        run_period(2, 2);
        check("rst_second_rise_pv", 32'(n_pvalid), 32'(pv0 + 1));
        check("rst_second_period", 32'(period_out), 32'd4);

        // one-cycle glitch: back-to-back rise/fall, period restarts from it
        repeat (3) drive(1'b0);
        drive(1'b1);
        repeat (5) drive(1'b0);
        check("glitch_rise_fall", 32'(last_fall - last_rise), 32'd1);
        run_period(2, 2);
        check("glitch_period", 32'(period_out), 32'd6);

        repeat (4) drive(1'b0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
